ldst_control_sequencer: RTL and testbench

Hardwired control sequencer that drives the datapath's micro-step control lines for the fetch, `ld`, `ldi` and `st` instruction family. It replaces hand-sequenced T0–T7 control with a registered state machine. The machine adds a memory-ready handshake with a configurable minimum wait, opcode decode, an illegal-opcode trap and back-to-back instruction issue. It sits beside the `Datapath` and connects one-to-one to its control inputs.

---
 rtl/ldst_control_sequencer_if.sv | 28 ++
 rtl/ldst_control_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_ldst_control_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ldst_control_sequencer_if.sv
// Control bundle between the ld/ldi/st sequencer (master) and the datapath (slave).
interface ldst_control_sequencer_if #(
  parameter int OPCODE_W = 5
);
  logic                Run;
  logic [OPCODE_W-1:0] IR_op;
  logic                Mem_ready;
  logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC;
  logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, ALU_add;
  logic [3:0]          State;
  logic                Done;
  logic                Illegal;
  logic                Halted;

  modport master (
    input  Run, IR_op, Mem_ready,
    output PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC,
    output Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, ALU_add,
    output State, Done, Illegal, Halted
  );

  modport slave (
    output Run, IR_op, Mem_ready,
    input  PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC,
    input  Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, ALU_add,
    input  State, Done, Illegal, Halted
  );
endinterface

// File: rtl/ldst_control_sequencer.sv
// Registered Moore sequencer for fetch + ld/ldi/st with a memory-ready handshake.
// Optional HALT state is built only when SEQ_HALT_EN is defined.
module ldst_control_sequencer #(
  parameter int                  OPCODE_W = 5,
  parameter logic [OPCODE_W-1:0] OP_LD    = 5'b00000,
  parameter logic [OPCODE_W-1:0] OP_LDI   = 5'b00001,
  parameter logic [OPCODE_W-1:0] OP_ST    = 5'b00010,
  parameter logic [OPCODE_W-1:0] OP_HALT  = 5'b11011,
  parameter int                  MEM_WAIT = 0
) (
  input logic                    Clock,
  input logic                    Reset,
  ldst_control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_T0      = 4'd1,
    S_T1      = 4'd2,
    S_T2      = 4'd3,
    S_T3      = 4'd4,
    S_T4      = 4'd5,
    S_T5      = 4'd6,
    S_T6      = 4'd7,
    S_T7      = 4'd8,
    S_ILLEGAL = 4'd9
`ifdef SEQ_HALT_EN
    , S_HALT  = 4'd10
`endif
  } state_e;

  typedef enum logic [1:0] {K_LD = 2'd0, K_LDI = 2'd1, K_ST = 2'd2} kind_e;

  typedef struct packed {
    logic pc_out, zlow_out, zhigh_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in, inc_pc;
    logic read, write, gra, grb, grc, r_in, r_out, ba_out, c_out, alu_add;
    logic done, illegal;
  } ctl_t;

  state_e     state_q, state_d, next_instr;
  kind_e      kind_q, kind_d;
  logic [3:0] wait_q, wait_d;
  ctl_t       ctl_q, ctl_d;
  logic       in_mem, mem_exit;
`ifdef SEQ_HALT_EN
  logic       halted_q, halted_d;
`endif

  function automatic ctl_t decode(state_e s, kind_e k);
    ctl_t c;
    c = '0;
    case (s)
      S_T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
      S_T1: begin c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
      S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      S_T3: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
      S_T4: begin c.c_out = 1'b1; c.alu_add = 1'b1; c.z_in = 1'b1; end
      S_T5: begin
        c.zlow_out = 1'b1;
        if (k == K_LDI) begin c.gra = 1'b1; c.r_in = 1'b1; c.done = 1'b1; end
        else c.mar_in = 1'b1;
      end
      S_T6: begin
        c.mdr_in = 1'b1;
        if (k == K_ST) begin c.gra = 1'b1; c.r_out = 1'b1; end
        else c.read = 1'b1;
      end
      S_T7: begin
        c.done = 1'b1;
        if (k == K_ST) c.write = 1'b1;
        else begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
      end
      S_ILLEGAL: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic; outputs are decoded from the next state so they register alongside it.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    wait_d     = wait_q;
    next_instr = bus.Run ? S_T0 : S_IDLE;
    in_mem     = (state_q == S_T1) ||
                 (state_q == S_T6 && kind_q == K_LD) ||
                 (state_q == S_T7 && kind_q == K_ST);
    mem_exit   = in_mem && (wait_q == 4'd0) && bus.Mem_ready;
    if (in_mem && wait_q != 4'd0) wait_d = wait_q - 4'd1;
    case (state_q)
      S_IDLE: if (bus.Run) state_d = S_T0;
      S_T0: begin state_d = S_T1; wait_d = 4'(MEM_WAIT); end
      S_T1: if (mem_exit) state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        if (bus.IR_op == OP_LD) begin kind_d = K_LD; state_d = S_T4; end
        else if (bus.IR_op == OP_LDI) begin kind_d = K_LDI; state_d = S_T4; end
        else if (bus.IR_op == OP_ST) begin kind_d = K_ST; state_d = S_T4; end
`ifdef SEQ_HALT_EN
        else if (bus.IR_op == OP_HALT) state_d = S_HALT;
`else
        else if (bus.IR_op == OP_HALT) state_d = S_ILLEGAL;
`endif
        else state_d = S_ILLEGAL;
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (kind_q == K_LDI) state_d = next_instr;
        else begin
          state_d = S_T6;
          if (kind_q == K_LD) wait_d = 4'(MEM_WAIT);
        end
      end
      S_T6: begin
        if (kind_q == K_ST) begin state_d = S_T7; wait_d = 4'(MEM_WAIT); end
        else if (mem_exit) state_d = S_T7;
      end
      S_T7: if (kind_q != K_ST || mem_exit) state_d = next_instr;
      S_ILLEGAL: state_d = next_instr;
`ifdef SEQ_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
    ctl_d = decode(state_d, kind_d);
`ifdef SEQ_HALT_EN
    halted_d = (state_d == S_HALT);
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_LD;
      wait_q  <= 4'd0;
      ctl_q   <= '0;
`ifdef SEQ_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      wait_q  <= wait_d;
      ctl_q   <= ctl_d;
`ifdef SEQ_HALT_EN
      halted_q <= halted_d;
`endif
    end
  end

  assign bus.PCout    = ctl_q.pc_out;
  assign bus.Zlowout  = ctl_q.zlow_out;
  assign bus.Zhighout = ctl_q.zhigh_out;
  assign bus.MDRout   = ctl_q.mdr_out;
  assign bus.MARin    = ctl_q.mar_in;
  assign bus.Zin      = ctl_q.z_in;
  assign bus.PCin     = ctl_q.pc_in;
  assign bus.MDRin    = ctl_q.mdr_in;
  assign bus.IRin     = ctl_q.ir_in;
  assign bus.Yin      = ctl_q.y_in;
  assign bus.IncPC    = ctl_q.inc_pc;
  assign bus.Read     = ctl_q.read;
  assign bus.Write    = ctl_q.write;
  assign bus.Gra      = ctl_q.gra;
  assign bus.Grb      = ctl_q.grb;
  assign bus.Grc      = ctl_q.grc;
  assign bus.Rin      = ctl_q.r_in;
  assign bus.Rout     = ctl_q.r_out;
  assign bus.BAout    = ctl_q.ba_out;
  assign bus.Cout     = ctl_q.c_out;
  assign bus.ALU_add  = ctl_q.alu_add;
  assign bus.Done     = ctl_q.done;
  assign bus.Illegal  = ctl_q.illegal;
  assign bus.State    = state_q;
`ifdef SEQ_HALT_EN
  assign bus.Halted   = halted_q;
`else
  assign bus.Halted   = 1'b0;
`endif

endmodule

// File: tb/tb_ldst_control_sequencer.sv
// Randomized bench: a per-instruction trace generator predicts every cycle of the sequencer.
// Build with SEQ_HALT_EN defined to exercise the HALT state.
module tb_ldst_control_sequencer;

  localparam int MW = 2;

  localparam logic [20:0] C_PCOUT  = 21'd1 << 20;
  localparam logic [20:0] C_ZLOW   = 21'd1 << 19;
  localparam logic [20:0] C_MDROUT = 21'd1 << 17;
  localparam logic [20:0] C_MARIN  = 21'd1 << 16;
  localparam logic [20:0] C_ZIN    = 21'd1 << 15;
  localparam logic [20:0] C_PCIN   = 21'd1 << 14;
  localparam logic [20:0] C_MDRIN  = 21'd1 << 13;
  localparam logic [20:0] C_IRIN   = 21'd1 << 12;
  localparam logic [20:0] C_YIN    = 21'd1 << 11;
  localparam logic [20:0] C_INCPC  = 21'd1 << 10;
  localparam logic [20:0] C_READ   = 21'd1 << 9;
  localparam logic [20:0] C_WRITE  = 21'd1 << 8;
  localparam logic [20:0] C_GRA    = 21'd1 << 7;
  localparam logic [20:0] C_GRB    = 21'd1 << 6;
  localparam logic [20:0] C_RIN    = 21'd1 << 4;
  localparam logic [20:0] C_ROUT   = 21'd1 << 3;
  localparam logic [20:0] C_BAOUT  = 21'd1 << 2;
  localparam logic [20:0] C_COUT   = 21'd1 << 1;
  localparam logic [20:0] C_ALU    = 21'd1 << 0;

  typedef struct {
    bit          rst, run, rdy;
    logic [4:0]  op;
    logic [3:0]  st;
    logic [20:0] ctl;
    bit          done, ill, halt, chk;
  } cyc_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ldst_control_sequencer_if #(.OPCODE_W(5)) bus();
  ldst_control_sequencer #(.MEM_WAIT(MW)) dut (.Clock(clk), .Reset(rst), .bus(bus));

  cyc_t q[$];
  cyc_t t[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   in_idle;

  // 0 ld, 1 ldi, 2 st, 3 halt, 4 illegal
  function automatic int classify(logic [4:0] op);
    if (op == 5'b00000) return 0;
    if (op == 5'b00001) return 1;
    if (op == 5'b00010) return 2;
`ifdef SEQ_HALT_EN
    if (op == 5'b11011) return 3;
`endif
    return 4;
  endfunction

  function automatic cyc_t mk(logic [3:0] st, logic [20:0] c, bit dn, bit il, bit hl);
    cyc_t r;
    r.st = st; r.ctl = c; r.done = dn; r.ill = il; r.halt = hl;
    r.run = 1'($urandom); r.rdy = 1'($urandom); r.op = 5'($urandom);
    r.rst = 1'b0; r.chk = 1'b1;
    return r;
  endfunction

  task automatic mem(input logic [3:0] st, input logic [20:0] c, input bit dn, input int d);
    int len;
    cyc_t r;
    len = (d > MW) ? d + 1 : MW + 1;
    for (int j = 0; j < len; j++) begin
      r = mk(st, c, dn, 1'b0, 1'b0);
      r.rdy = (j >= d);
      t.push_back(r);
    end
  endtask

  task automatic gen_instr(input logic [4:0] op, input int d1, input int d2, input bit run_last);
    cyc_t r;
    int   k;
    k = classify(op);
    t.delete();
    t.push_back(mk(4'd1, C_PCOUT | C_MARIN | C_INCPC | C_ZIN, 0, 0, 0));
    mem(4'd2, C_ZLOW | C_PCIN | C_READ | C_MDRIN, 0, d1);
    t.push_back(mk(4'd3, C_MDROUT | C_IRIN, 0, 0, 0));
    r = mk(4'd4, C_GRB | C_BAOUT | C_YIN, 0, 0, 0);
    r.op = op;
    t.push_back(r);
    case (k)
      0: begin
        t.push_back(mk(4'd5, C_COUT | C_ALU | C_ZIN, 0, 0, 0));
        t.push_back(mk(4'd6, C_ZLOW | C_MARIN, 0, 0, 0));
        mem(4'd7, C_READ | C_MDRIN, 0, d2);
        t.push_back(mk(4'd8, C_MDROUT | C_GRA | C_RIN, 1, 0, 0));
      end
      1: begin
        t.push_back(mk(4'd5, C_COUT | C_ALU | C_ZIN, 0, 0, 0));
        t.push_back(mk(4'd6, C_ZLOW | C_GRA | C_RIN, 1, 0, 0));
      end
      2: begin
        t.push_back(mk(4'd5, C_COUT | C_ALU | C_ZIN, 0, 0, 0));
        t.push_back(mk(4'd6, C_ZLOW | C_MARIN, 0, 0, 0));
        t.push_back(mk(4'd7, C_GRA | C_ROUT | C_MDRIN, 0, 0, 0));
        mem(4'd8, C_WRITE, 1, d2);
      end
      3: begin
        for (int j = 0; j < 2 + int'($urandom % 4); j++) t.push_back(mk(4'd10, '0, 0, 0, 1));
      end
      default: t.push_back(mk(4'd9, '0, 0, 1, 0));
    endcase
    r = t.pop_back();
    r.run = run_last;
    t.push_back(r);
  endtask

  // Appends one instruction (with any IDLE lead-in) to the plan; cut>=0 forces Reset at that cycle.
  task automatic issue(input logic [4:0] op, input int d1, input int d2, input bit run_last, input int cut);
    cyc_t r;
    bit   was_reset;
    if (in_idle) begin
      for (int j = 0; j < int'($urandom % 3); j++) begin
        r = mk(4'd0, '0, 0, 0, 0);
        r.run = 1'b0;
        q.push_back(r);
      end
      r = mk(4'd0, '0, 0, 0, 0);
      r.run = 1'b1;
      q.push_back(r);
    end
    gen_instr(op, d1, d2, run_last);
    was_reset = (classify(op) == 3);
    if (cut >= 0 && cut < t.size()) begin
      while (t.size() > cut + 1) r = t.pop_back();
      was_reset = 1'b1;
    end
    if (was_reset) begin
      r = t.pop_back();
      r.rst = 1'b1;
      t.push_back(r);
    end
    foreach (t[i]) q.push_back(t[i]);
    in_idle = was_reset ? 1'b1 : !run_last;
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input cyc_t r);
    rst           = r.rst;
    bus.Run       = r.run;
    bus.IR_op     = r.op;
    bus.Mem_ready = r.rdy;
  endtask

  function automatic logic [27:0] observed();
    return {bus.State,
            bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.MARin, bus.Zin, bus.PCin,
            bus.MDRin, bus.IRin, bus.Yin, bus.IncPC, bus.Read, bus.Write, bus.Gra, bus.Grb,
            bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.Cout, bus.ALU_add,
            bus.Done, bus.Illegal, bus.Halted};
  endfunction

  initial begin
    cyc_t        r;
    int          cnt;
    int          kind_pick;
    logic [4:0]  op;
    logic [27:0] exp_v, act_v;

    // Hand-computed pins of the trace generator with MEM_WAIT=2.
    gen_instr(5'b00000, 0, 0, 1'b1);
    check_output("ld_latency_model", t.size(), 12);
    gen_instr(5'b00001, 0, 0, 1'b1);
    check_output("ldi_latency_model", t.size(), 8);
    gen_instr(5'b00010, 0, 4, 1'b1);
    cnt = 0;
    foreach (t[i]) if ((t[i].ctl & C_WRITE) != 0) cnt++;
    check_output("st_write_width_model", cnt, 5);
    cnt = 0;
    foreach (t[i]) if (t[i].st == 4'd2) cnt++;
    check_output("st_t1_width_model", cnt, 3);
    gen_instr(5'b10101, 0, 0, 1'b1);
    check_output("illegal_latency_model", t.size(), 7);
    check_output("illegal_last_flag_model", int'(t[t.size()-1].ill), 1);

    // Build plan: reset, directed instructions, then random traffic.
    r = mk(4'd0, '0, 0, 0, 0);
    r.rst = 1'b1; r.chk = 1'b0;
    q.push_back(r);
    in_idle = 1'b1;
    issue(5'b00000, 0, 0, 1'b1, -1);
    issue(5'b00000, 0, 0, 1'b1, -1);
    issue(5'b00001, 0, 0, 1'b1, -1);
    issue(5'b00010, 0, 4, 1'b0, -1);
    issue(5'b10101, 0, 0, 1'b1, -1);
    issue(5'b10101, 0, 0, 1'b0, -1);
    issue(5'b00000, 0, 0, 1'b1, 8);
    issue(5'b00000, 1, 3, 1'b1, -1);
    issue(5'b11011, 0, 0, 1'b1, -1);
    for (int n = 0; n < 200; n++) begin
      kind_pick = int'($urandom % 10);
      op = (kind_pick < 6) ? 5'(kind_pick % 3) : 5'($urandom);
      issue(op, int'($urandom % 7), int'($urandom % 7), ($urandom % 4) != 0,
            ($urandom % 15 == 0) ? int'($urandom % 14) : -1);
    end

    // Compare every cycle on the falling edge, then drive that cycle's inputs.
    apply_stimulus(q[0]);
    for (int k = 1; k < q.size(); k++) begin
      @(negedge clk);
      if (q[k].chk) begin
        exp_v = {q[k].st, q[k].ctl, q[k].done, q[k].ill, q[k].halt};
        act_v = observed();
        n_chk++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("[TB] FAIL cycle_%0d outputs: got %h, expected %h", k, act_v, exp_v);
        end
      end
      apply_stimulus(q[k]);
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
